ff_addsub: RTL and testbench

//  Limb-serial modular adder/subtractor over GF(P): out = (a+b) mod P or (a-b) mod P, chosen per operation.

---
 rtl/ff_addsub.sv | 190 +++++++++++++++++++
 tb/tb_ff_addsub.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ff_addsub.sv
// ff_addsub - limb-serial modular adder/subtractor over GF(P).
//
// Computes out = (a + b) mod P when op = 0, or (a - b) mod P when op = 1.
// The operands are zero-extended to W = NLIMBS*LIMB_W bits and processed
// one limb per cycle through a two-stage limb pipeline:
//   stage 1: raw limb sum/difference r = a +/- b
//   stage 2: correction candidate t = r - P (add) or r + P (sub),
//            running one cycle behind stage 1
// In the FINAL cycle the carry/borrow out of the chains selects r or t.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous reset, active low
//   start  in   1        request, sampled only while idle
//   op     in   1        0 = add, 1 = subtract (latched with start)
//   a_i    in   FIELD_W  operand a, reduced (< P)
//   b_i    in   FIELD_W  operand b, reduced (< P)
//   busy   out  1        high from the cycle after acceptance until done
//   done   out  1        one-cycle pulse, out valid in that cycle
//   out    out  FIELD_W  registered result, held until the next done
module ff_addsub #(
  parameter int unsigned        FIELD_W = 255,
  parameter int unsigned        LIMB_W  = 64,
  parameter int unsigned        NLIMBS  = 4,
  parameter logic [FIELD_W-1:0] P       = 255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op,
  input  logic [FIELD_W-1:0] a_i,
  input  logic [FIELD_W-1:0] b_i,
  output logic               busy,
  output logic               done,
  output logic [FIELD_W-1:0] out
);

  localparam int unsigned W  = NLIMBS * LIMB_W;
  localparam int unsigned KW = $clog2(NLIMBS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NLIMBS);

  // The raw result needs one spare bit above FIELD_W so a+b never overflows.
  if (NLIMBS * LIMB_W < FIELD_W + 1) begin : g_cfg_err
    $error("ff_addsub: NLIMBS*LIMB_W must be at least FIELD_W+1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               op_q;
  logic [W-1:0]       a_q, b_q, p_q;   // shift right one limb per stage step
  logic [W-1:0]       r_q, t_q;        // filled from the top, one limb per step
  logic               c1_q, c2_q;      // stage 1 / stage 2 carry-or-borrow
  logic               busy_q, done_q;
  logic [FIELD_W-1:0] out_q;

  logic               s1_en, s2_en;
  logic [LIMB_W:0]    s1_sum, s2_sum;

  assign s1_en = (state_q == S_RUN) && (k_q != K_LAST);
  assign s2_en = (state_q == S_RUN) && (k_q != {KW{1'b0}});

  // Limb arithmetic for both stages. The top bit of each sum is the carry
  // (add) or the borrow (subtract) into the next limb. Stage 2 reads the
  // top limb of r_q, which is the limb stage 1 produced one cycle earlier.
  always_comb begin
    s1_sum = {(LIMB_W + 1){1'b0}};
    s2_sum = {(LIMB_W + 1){1'b0}};
    if (op_q) begin
      s1_sum = {1'b0, a_q[LIMB_W-1:0]} - {1'b0, b_q[LIMB_W-1:0]}
             - {{LIMB_W{1'b0}}, c1_q};
      s2_sum = {1'b0, r_q[W-1 -: LIMB_W]} + {1'b0, p_q[LIMB_W-1:0]}
             + {{LIMB_W{1'b0}}, c2_q};
    end else begin
      s1_sum = {1'b0, a_q[LIMB_W-1:0]} + {1'b0, b_q[LIMB_W-1:0]}
             + {{LIMB_W{1'b0}}, c1_q};
      s2_sum = {1'b0, r_q[W-1 -: LIMB_W]} - {1'b0, p_q[LIMB_W-1:0]}
             - {{LIMB_W{1'b0}}, c2_q};
    end
  end

  // Next-state and limb counter logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = {KW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_FINAL;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_FINAL: begin
        state_d = S_IDLE;
        k_d     = {KW{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
        k_d     = {KW{1'b0}};
      end
    endcase
  end

  // State, counter and status flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= {KW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_FINAL);
    end
  end

  // Operand latch, limb pipeline and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 1'b0;
      a_q   <= {W{1'b0}};
      b_q   <= {W{1'b0}};
      p_q   <= {W{1'b0}};
      r_q   <= {W{1'b0}};
      t_q   <= {W{1'b0}};
      c1_q  <= 1'b0;
      c2_q  <= 1'b0;
      out_q <= {FIELD_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= W'(a_i);
            b_q  <= W'(b_i);
            p_q  <= W'(P);
            c1_q <= 1'b0;
            c2_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (s1_en) begin
            a_q  <= a_q >> LIMB_W;
            b_q  <= b_q >> LIMB_W;
            r_q  <= (r_q >> LIMB_W) | (W'(s1_sum[LIMB_W-1:0]) << (W - LIMB_W));
            c1_q <= s1_sum[LIMB_W];
          end
          if (s2_en) begin
            p_q  <= p_q >> LIMB_W;
            t_q  <= (t_q >> LIMB_W) | (W'(s2_sum[LIMB_W-1:0]) << (W - LIMB_W));
            c2_q <= s2_sum[LIMB_W];
          end
        end
        S_FINAL: begin
          // add: a borrow out of r-P means r < P, keep r.
          // sub: a borrow out of a-b means a < b, take r+P.
          if (op_q) begin
            out_q <= c1_q ? t_q[FIELD_W-1:0] : r_q[FIELD_W-1:0];
          end else begin
            out_q <= c2_q ? r_q[FIELD_W-1:0] : t_q[FIELD_W-1:0];
          end
        end
        default: begin
          out_q <= out_q;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_ff_addsub.sv
module tb_ff_addsub;

  localparam logic [254:0] PM = 255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
  localparam int LAT0 = 6;    // 64-bit limbs x 4
  localparam int LAT1 = 10;   // 32-bit limbs x 8

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [254:0] a = '0, b = '0;
  logic         busy0, done0, busy1, done1;
  logic [254:0] out0, out1;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  ff_addsub #(.FIELD_W(255), .LIMB_W(64), .NLIMBS(4), .P(PM)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_i(a), .b_i(b),
    .busy(busy0), .done(done0), .out(out0));

  ff_addsub #(.FIELD_W(255), .LIMB_W(32), .NLIMBS(8), .P(PM)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_i(a), .b_i(b),
    .busy(busy1), .done(done1), .out(out1));

  // Golden modular arithmetic on reduced operands.
  function automatic logic [254:0] golden(input logic o, input logic [254:0] x, input logic [254:0] y);
    logic [255:0] s;
    if (!o) begin
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, PM}) s = s - {1'b0, PM};
    end else if (x >= y) begin
      s = {1'b0, x} - {1'b0, y};
    end else begin
      s = {1'b0, x} + {1'b0, PM} - {1'b0, y};
    end
    return s[254:0];
  endfunction

  function automatic logic [254:0] rnd_elem();
    logic [255:0] w;
    logic [254:0] v;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    v = w[254:0];
    if (v >= PM) v = v - PM;
    case ($urandom_range(7))
      0: v = PM - 255'($urandom_range(3)) - 255'd1;
      1: v = 255'($urandom_range(3));
      default: v = v;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [254:0] act, input logic [254:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Timing-level reference: each DUT is idle or counting down its latency.
  int           cnt_m  [2];
  logic [254:0] pend_m [2];
  logic [254:0] exp_out[2];
  logic         exp_done[2];
  int           lat_m  [2];

  initial begin
    lat_m[0] = LAT0;
    lat_m[1] = LAT1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        cnt_m[d]    <= 0;
        pend_m[d]   <= '0;
        exp_out[d]  <= '0;
        exp_done[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_done[d] <= 1'b0;
        if (cnt_m[d] == 0) begin
          if (start) begin
            cnt_m[d]  <= lat_m[d];
            pend_m[d] <= golden(op, a, b);
          end
        end else begin
          cnt_m[d] <= cnt_m[d] - 1;
          if (cnt_m[d] == 1) begin
            exp_done[d] <= 1'b1;
            exp_out[d]  <= pend_m[d];
          end
        end
      end
    end
  end

  // Per-cycle comparison of both DUTs against the reference.
  always @(negedge clk) begin
    chk("busy0", 255'(busy0), 255'(cnt_m[0] != 0));
    chk("done0", 255'(done0), 255'(exp_done[0]));
    chk("out0",  out0, exp_out[0]);
    chk("busy1", 255'(busy1), 255'(cnt_m[1] != 0));
    chk("done1", 255'(done1), 255'(exp_done[1]));
    chk("out1",  out1, exp_out[1]);
  end

  // One operation on both DUTs, checked against a hand-computed result.
  task automatic run_op(input string nm, input logic o, input logic [254:0] x,
                        input logic [254:0] y, input logic [254:0] want);
    int lt0, lt1, bz0, bz1;
    logic [254:0] c0, c1;
    lt0 = -1; lt1 = -1; bz0 = 0; bz1 = 0; c0 = '0; c1 = '0;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    for (int n = 0; n <= 20 && (lt0 < 0 || lt1 < 0); n++) begin
      @(negedge clk);
      if (n >= 1 && busy0) bz0++;
      if (n >= 1 && busy1) bz1++;
      if (done0 && lt0 < 0) begin lt0 = n; c0 = out0; end
      if (done1 && lt1 < 0) begin lt1 = n; c1 = out1; end
    end
    chk({nm, "_out64"}, c0, want);
    chk({nm, "_out32"}, c1, want);
    chk_int({nm, "_lat64"}, lt0, LAT0);
    chk_int({nm, "_lat32"}, lt1, LAT1);
    chk_int({nm, "_busy64"}, bz0, LAT0 - 1);
    chk_int({nm, "_busy32"}, bz1, LAT1 - 1);
  endtask

  logic [254:0] big;

  initial begin
    // model pins
    chk("gold_add_wrap", golden(1'b0, PM - 255'd1, 255'd1), 255'd0);
    chk("gold_sub_neg",  golden(1'b1, 255'd0, 255'd1), PM - 255'd1);
    chk("gold_sub_53",   golden(1'b1, 255'd5, 255'd3), 255'd2);
    chk("gold_add_max",  golden(1'b0, PM - 255'd1, PM - 255'd1), PM - 255'd2);

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 255'({busy0, busy1, done0, done1}), 255'd0);
    chk("rst_out", out0 | out1, 255'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_wrap", 1'b0, PM - 255'd1, 255'd1, 255'd0);
    run_op("sub_0m1", 1'b1, 255'd0, 255'd1, PM - 255'd1);
    run_op("sub_5m3", 1'b1, 255'd5, 255'd3, 255'd2);
    big = (255'd1 << 200) + 255'd7;
    run_op("sub_eq", 1'b1, big, big, 255'd0);
    run_op("add_c64", 1'b0, (255'd1 << 64) - 255'd1, 255'd1, 255'd1 << 64);
    run_op("add_c32", 1'b0, (255'd1 << 32) - 255'd1, 255'd1, 255'd1 << 32);
    run_op("add_max", 1'b0, PM - 255'd1, PM - 255'd1, PM - 255'd2);

    // start held high, op and operands changing every cycle
    start = 1'b1; op = 1'b0; a = rnd_elem(); b = rnd_elem();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #2 op = ~op; a = rnd_elem(); b = rnd_elem();
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    // reset in the middle of an operation (limb k=2 of u0)
    op = 1'b0; a = PM - 255'd1; b = 255'd5; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_flags", 255'({busy0, busy1, done0, done1}), 255'd0);
    chk("abort_out", out0 | out1, 255'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op("add_7p8", 1'b0, 255'd7, 255'd8, 255'd15);

    // random reduced operations with bursts of held start
    for (int i = 0; i < 12000; i++) begin
      @(posedge clk);
      #2;
      start = ($urandom_range(3) != 0);
      op    = 1'($urandom_range(1));
      a     = rnd_elem();
      b     = rnd_elem();
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
